// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates on dispatch, resolves operands,
// captures FU results and retires in program order.
module reorder_buffer #(
  parameter int ROB_ENTRIES  = 8,
  parameter int ROB_IDX_SIZE = 3,
  parameter int GPR_SIZE     = 64,
  parameter int GPR_IDX_SIZE = 5
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rg_done,
  input  logic [GPR_IDX_SIZE-1:0] in_rg_dst,
  input  logic                    in_rg_set_nzcv,
  input  logic                    in_rg_src1_valid,
  input  logic                    in_rg_src2_valid,
  input  logic [GPR_SIZE-1:0]     in_rg_src1_value,
  input  logic [GPR_SIZE-1:0]     in_rg_src2_value,
  input  logic [ROB_IDX_SIZE-1:0] in_rg_src1_rob_index,
  input  logic [ROB_IDX_SIZE-1:0] in_rg_src2_rob_index,
  input  logic                    in_fu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
  input  logic [GPR_SIZE-1:0]     in_fu_value,
  input  logic [3:0]              in_fu_nzcv,
  output logic [ROB_IDX_SIZE-1:0] out_reg_next_rob_index,
  output logic                    out_full,
  output logic                    out_rs_done,
  output logic [ROB_IDX_SIZE-1:0] out_rs_rob_index,
  output logic                    out_rs_src1_valid,
  output logic                    out_rs_src2_valid,
  output logic [GPR_SIZE-1:0]     out_rs_src1_value,
  output logic [GPR_SIZE-1:0]     out_rs_src2_value,
  output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
  output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
  output logic                    out_reg_should_commit,
  output logic [ROB_IDX_SIZE-1:0] out_reg_commit_rob_index,
  output logic [GPR_IDX_SIZE-1:0] out_reg_reg_index,
  output logic [GPR_SIZE-1:0]     out_reg_commit_value,
  output logic                    out_reg_set_nzcv,
  output logic [3:0]              out_reg_nzcv,
  output logic                    out_overflow
);

  localparam int CW = ROB_IDX_SIZE + 1;

  logic [ROB_IDX_SIZE-1:0] head_q, tail_q;
  logic [CW-1:0]           count_q, count_d;
  logic [ROB_ENTRIES-1:0]  valid_q, done_q, nz_q;
  logic [GPR_IDX_SIZE-1:0] dst_q  [ROB_ENTRIES];
  logic [GPR_SIZE-1:0]     val_q  [ROB_ENTRIES];
  logic [3:0]              nzcv_q [ROB_ENTRIES];

  logic                    acc, cm;
  logic                    s1v_d, s2v_d;
  logic [GPR_SIZE-1:0]     s1val_d, s2val_d;

  assign out_reg_next_rob_index = tail_q;
  assign out_full = (count_q == CW'(ROB_ENTRIES));
  assign acc      = in_rg_done && !out_full;
  assign cm       = (count_q != '0) && done_q[head_q];
  assign count_d  = count_q + CW'(acc) - CW'(cm);

  // FU bypass wins over the stored result
  always_comb begin
    s1v_d   = in_rg_src1_valid;
    s1val_d = in_rg_src1_value;
    if (!in_rg_src1_valid) begin
      if (in_fu_done && in_fu_rob_index == in_rg_src1_rob_index) begin
        s1v_d   = 1'b1;
        s1val_d = in_fu_value;
      end else if (done_q[in_rg_src1_rob_index]) begin
        s1v_d   = 1'b1;
        s1val_d = val_q[in_rg_src1_rob_index];
      end
    end
    s2v_d   = in_rg_src2_valid;
    s2val_d = in_rg_src2_value;
    if (!in_rg_src2_valid) begin
      if (in_fu_done && in_fu_rob_index == in_rg_src2_rob_index) begin
        s2v_d   = 1'b1;
        s2val_d = in_fu_value;
      end else if (done_q[in_rg_src2_rob_index]) begin
        s2v_d   = 1'b1;
        s2val_d = val_q[in_rg_src2_rob_index];
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      nz_q    <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        dst_q[i]  <= '0;
        val_q[i]  <= '0;
        nzcv_q[i] <= '0;
      end
      out_rs_done              <= 1'b0;
      out_rs_rob_index         <= '0;
      out_rs_src1_valid        <= 1'b0;
      out_rs_src2_valid        <= 1'b0;
      out_rs_src1_value        <= '0;
      out_rs_src2_value        <= '0;
      out_rs_src1_rob_index    <= '0;
      out_rs_src2_rob_index    <= '0;
      out_reg_should_commit    <= 1'b0;
      out_reg_commit_rob_index <= '0;
      out_reg_reg_index        <= '0;
      out_reg_commit_value     <= '0;
      out_reg_set_nzcv         <= 1'b0;
      out_reg_nzcv             <= '0;
      out_overflow             <= 1'b0;
    end else begin
      if (in_fu_done && valid_q[in_fu_rob_index]) begin
        val_q[in_fu_rob_index]  <= in_fu_value;
        nzcv_q[in_fu_rob_index] <= in_fu_nzcv;
        done_q[in_fu_rob_index] <= 1'b1;
      end
      out_reg_should_commit <= cm;
      if (cm) begin
        valid_q[head_q]          <= 1'b0;
        done_q[head_q]           <= 1'b0;
        head_q                   <= head_q + ROB_IDX_SIZE'(1);
        out_reg_commit_rob_index <= head_q;
        out_reg_reg_index        <= dst_q[head_q];
        out_reg_commit_value     <= val_q[head_q];
        out_reg_set_nzcv         <= nz_q[head_q];
        out_reg_nzcv             <= nzcv_q[head_q];
      end
      if (acc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        dst_q[tail_q]   <= in_rg_dst;
        nz_q[tail_q]    <= in_rg_set_nzcv;
        tail_q          <= tail_q + ROB_IDX_SIZE'(1);
      end
      if (in_rg_done && out_full) out_overflow <= 1'b1;
      count_q               <= count_d;
      out_rs_done           <= acc;
      out_rs_rob_index      <= tail_q;
      out_rs_src1_valid     <= s1v_d;
      out_rs_src2_valid     <= s2v_d;
      out_rs_src1_value     <= s1val_d;
      out_rs_src2_value     <= s2val_d;
      out_rs_src1_rob_index <= in_rg_src1_rob_index;
      out_rs_src2_rob_index <= in_rg_src2_rob_index;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, corner sequences and a
// randomized run against a queue-based model.
module tb_reorder_buffer;

  logic        in_clk = 0;
  logic        in_rst = 0;
  logic        in_rg_done = 0;
  logic [4:0]  in_rg_dst = 0;
  logic        in_rg_set_nzcv = 0;
  logic        in_rg_src1_valid = 0, in_rg_src2_valid = 0;
  logic [63:0] in_rg_src1_value = 0, in_rg_src2_value = 0;
  logic [2:0]  in_rg_src1_rob_index = 0, in_rg_src2_rob_index = 0;
  logic        in_fu_done = 0;
  logic [2:0]  in_fu_rob_index = 0;
  logic [63:0] in_fu_value = 0;
  logic [3:0]  in_fu_nzcv = 0;

  logic [2:0]  out_reg_next_rob_index;
  logic        out_full, out_rs_done;
  logic [2:0]  out_rs_rob_index;
  logic        out_rs_src1_valid, out_rs_src2_valid;
  logic [63:0] out_rs_src1_value, out_rs_src2_value;
  logic [2:0]  out_rs_src1_rob_index, out_rs_src2_rob_index;
  logic        out_reg_should_commit;
  logic [2:0]  out_reg_commit_rob_index;
  logic [4:0]  out_reg_reg_index;
  logic [63:0] out_reg_commit_value;
  logic        out_reg_set_nzcv;
  logic [3:0]  out_reg_nzcv;
  logic        out_overflow;

  reorder_buffer dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_rg_done(in_rg_done), .in_rg_dst(in_rg_dst),
    .in_rg_set_nzcv(in_rg_set_nzcv),
    .in_rg_src1_valid(in_rg_src1_valid),
    .in_rg_src2_valid(in_rg_src2_valid),
    .in_rg_src1_value(in_rg_src1_value),
    .in_rg_src2_value(in_rg_src2_value),
    .in_rg_src1_rob_index(in_rg_src1_rob_index),
    .in_rg_src2_rob_index(in_rg_src2_rob_index),
    .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index),
    .in_fu_value(in_fu_value), .in_fu_nzcv(in_fu_nzcv),
    .out_reg_next_rob_index(out_reg_next_rob_index),
    .out_full(out_full), .out_rs_done(out_rs_done),
    .out_rs_rob_index(out_rs_rob_index),
    .out_rs_src1_valid(out_rs_src1_valid),
    .out_rs_src2_valid(out_rs_src2_valid),
    .out_rs_src1_value(out_rs_src1_value),
    .out_rs_src2_value(out_rs_src2_value),
    .out_rs_src1_rob_index(out_rs_src1_rob_index),
    .out_rs_src2_rob_index(out_rs_src2_rob_index),
    .out_reg_should_commit(out_reg_should_commit),
    .out_reg_commit_rob_index(out_reg_commit_rob_index),
    .out_reg_reg_index(out_reg_reg_index),
    .out_reg_commit_value(out_reg_commit_value),
    .out_reg_set_nzcv(out_reg_set_nzcv),
    .out_reg_nzcv(out_reg_nzcv),
    .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference model: in-flight instructions in program order
  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  dst;
    bit          nz;
    bit          done;
    logic [63:0] val;
    logic [3:0]  nzcv;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  mtail;
  bit          movf;
  bit          e_rsd, e_cm, e_s1v, e_s2v, e_cnz;
  logic [2:0]  e_rsi, e_s1t, e_s2t, e_ci;
  logic [63:0] e_s1val, e_s2val, e_cv;
  logic [4:0]  e_cr;
  logic [3:0]  e_cnzcv;

  task automatic model_clear();
    q.delete();
    mtail = 0;
    movf  = 0;
  endtask

  function automatic void resolve(input bit v, input logic [63:0] val,
                                  input logic [2:0] tag, output bit ov,
                                  output logic [63:0] oval);
    ov = v;
    oval = val;
    if (!v) begin
      if (in_fu_done && in_fu_rob_index == tag) begin
        ov = 1;
        oval = in_fu_value;
      end else begin
        foreach (q[i])
          if (q[i].idx == tag && q[i].done) begin
            ov = 1;
            oval = q[i].val;
          end
      end
    end
  endfunction

  task automatic predict();
    bit full, acc;
    ent_t n;
    full = (q.size() == 8);
    acc  = in_rg_done && !full;
    if (in_rg_done && full) movf = 1;
    e_rsd = acc;
    e_rsi = mtail;
    e_s1t = in_rg_src1_rob_index;
    e_s2t = in_rg_src2_rob_index;
    resolve(in_rg_src1_valid, in_rg_src1_value, e_s1t, e_s1v, e_s1val);
    resolve(in_rg_src2_valid, in_rg_src2_value, e_s2t, e_s2v, e_s2val);
    e_cm = (q.size() > 0) && q[0].done;
    if (e_cm) begin
      e_ci = q[0].idx; e_cr = q[0].dst; e_cv = q[0].val;
      e_cnz = q[0].nz; e_cnzcv = q[0].nzcv;
    end
    if (in_fu_done)
      foreach (q[i])
        if (q[i].idx == in_fu_rob_index) begin
          q[i].done = 1;
          q[i].val  = in_fu_value;
          q[i].nzcv = in_fu_nzcv;
        end
    if (e_cm) void'(q.pop_front());
    if (acc) begin
      n.idx = mtail; n.dst = in_rg_dst; n.nz = in_rg_set_nzcv;
      n.done = 0; n.val = 0; n.nzcv = 0;
      q.push_back(n);
      mtail = mtail + 3'd1;
    end
  endtask

  task automatic cyc();
    predict();
    @(posedge in_clk);
    #1;
    chk("next_idx", out_reg_next_rob_index, mtail);
    chk("full", out_full, q.size() == 8);
    chk("overflow", out_overflow, movf);
    chk("rs_done", out_rs_done, e_rsd);
    if (e_rsd) begin
      chk("rs_idx", out_rs_rob_index, e_rsi);
      chk("s1_valid", out_rs_src1_valid, e_s1v);
      if (e_s1v) chk("s1_value", out_rs_src1_value, e_s1val);
      else chk("s1_tag", out_rs_src1_rob_index, e_s1t);
      chk("s2_valid", out_rs_src2_valid, e_s2v);
      if (e_s2v) chk("s2_value", out_rs_src2_value, e_s2val);
      else chk("s2_tag", out_rs_src2_rob_index, e_s2t);
    end
    chk("commit", out_reg_should_commit, e_cm);
    if (e_cm) begin
      chk("c_idx", out_reg_commit_rob_index, e_ci);
      chk("c_reg", out_reg_reg_index, e_cr);
      chk("c_val", out_reg_commit_value, e_cv);
      chk("c_setnz", out_reg_set_nzcv, e_cnz);
      chk("c_nzcv", out_reg_nzcv, e_cnzcv);
    end
  endtask

  task automatic idle_in();
    in_rg_done = 0; in_rg_dst = 0; in_rg_set_nzcv = 0;
    in_rg_src1_valid = 1; in_rg_src2_valid = 1;
    in_rg_src1_value = 0; in_rg_src2_value = 0;
    in_rg_src1_rob_index = 0; in_rg_src2_rob_index = 0;
    in_fu_done = 0; in_fu_rob_index = 0;
    in_fu_value = 0; in_fu_nzcv = 0;
  endtask

  task automatic do_reset();
    idle_in();
    in_rst = 1;
    @(posedge in_clk);
    #1;
    chk("rst_next", out_reg_next_rob_index, 0);
    chk("rst_full", out_full, 0);
    chk("rst_rs_done", out_rs_done, 0);
    chk("rst_commit", out_reg_should_commit, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_cval", out_reg_commit_value, 0);
    in_rst = 0;
    model_clear();
  endtask

  typedef struct {
    logic       rg;
    logic [4:0] dst;
    logic       fu;
    logic [2:0] fi;
    logic [63:0] fv;
    logic [2:0] nx;
    logic       rsd;
    logic [2:0] rsi;
    logic       cm;
    logic [2:0] ci;
    logic [4:0] cr;
    logic [63:0] cv;
  } vec_t;

  function automatic vec_t mk(int rg, int dst, int fu, int fi, int fv,
                              int nx, int rsd, int rsi,
                              int cm, int ci, int cr, int cv);
    vec_t v;
    v.rg = rg[0]; v.dst = dst[4:0]; v.fu = fu[0]; v.fi = fi[2:0];
    v.fv = 64'(fv); v.nx = nx[2:0]; v.rsd = rsd[0]; v.rsi = rsi[2:0];
    v.cm = cm[0]; v.ci = ci[2:0]; v.cr = cr[4:0]; v.cv = 64'(cv);
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 2, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0);
    tbl[2] = mk(1, 3, 0, 0, 0,  3, 1, 2, 0, 0, 0, 0);
    tbl[3] = mk(0, 0, 1, 2, 30, 3, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 1, 0, 10, 3, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 0, 1, 1, 20, 3, 0, 0, 1, 0, 1, 10);
    tbl[6] = mk(0, 0, 0, 0, 0,  3, 0, 0, 1, 1, 2, 20);
    tbl[7] = mk(0, 0, 0, 0, 0,  3, 0, 0, 1, 2, 3, 30);
    tbl[8] = mk(0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0);

    model_clear();
    #2;
    do_reset();

    foreach (tbl[i]) begin
      idle_in();
      in_rg_done = tbl[i].rg; in_rg_dst = tbl[i].dst;
      in_fu_done = tbl[i].fu; in_fu_rob_index = tbl[i].fi;
      in_fu_value = tbl[i].fv;
      cyc();
      chk("t_next", out_reg_next_rob_index, tbl[i].nx);
      chk("t_rsd", out_rs_done, tbl[i].rsd);
      if (tbl[i].rsd) chk("t_rsi", out_rs_rob_index, tbl[i].rsi);
      chk("t_cm", out_reg_should_commit, tbl[i].cm);
      if (tbl[i].cm) begin
        chk("t_ci", out_reg_commit_rob_index, tbl[i].ci);
        chk("t_cr", out_reg_reg_index, tbl[i].cr);
        chk("t_cv", out_reg_commit_value, tbl[i].cv);
      end
    end

    // same-cycle FU bypass onto a dispatching operand
    idle_in();
    in_rg_done = 1; in_rg_dst = 5;
    cyc();
    idle_in();
    in_rg_done = 1; in_rg_dst = 6;
    in_rg_src1_valid = 0; in_rg_src1_rob_index = 3;
    in_rg_src2_valid = 1; in_rg_src2_value = 64'h77;
    in_fu_done = 1; in_fu_rob_index = 3; in_fu_value = 64'h55;
    cyc();
    chk("byp_rsi", out_rs_rob_index, 4);
    chk("byp_s1v", out_rs_src1_valid, 1);
    chk("byp_s1val", out_rs_src1_value, 64'h55);
    chk("byp_s2v", out_rs_src2_valid, 1);
    chk("byp_s2val", out_rs_src2_value, 64'h77);

    // fill, overflow, drain one, wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle_in();
      in_rg_done = 1; in_rg_dst = 5'(i + 1);
      cyc();
    end
    chk("fill_full", out_full, 1);
    chk("fill_next", out_reg_next_rob_index, 0);
    in_rg_dst = 9;
    cyc();
    chk("ovf_set", out_overflow, 1);
    chk("ovf_tail", out_reg_next_rob_index, 0);
    chk("ovf_rsd", out_rs_done, 0);
    idle_in();
    in_fu_done = 1; in_fu_rob_index = 0; in_fu_value = 64'hA;
    cyc();
    idle_in();
    cyc();
    chk("drain_cm", out_reg_should_commit, 1);
    chk("drain_full", out_full, 0);
    in_rg_done = 1; in_rg_dst = 10;
    cyc();
    chk("wrap_rsi", out_rs_rob_index, 0);
    chk("wrap_next", out_reg_next_rob_index, 1);
    chk("ovf_sticky", out_overflow, 1);

    // flags carried to commit
    do_reset();
    idle_in();
    in_rg_done = 1; in_rg_dst = 7; in_rg_set_nzcv = 1;
    cyc();
    idle_in();
    in_fu_done = 1; in_fu_rob_index = 0;
    in_fu_value = 64'h9; in_fu_nzcv = 4'b0100;
    cyc();
    idle_in();
    cyc();
    chk("nz_cm", out_reg_should_commit, 1);
    chk("nz_set", out_reg_set_nzcv, 1);
    chk("nz_val", out_reg_nzcv, 4'b0100);
    chk("nz_cval", out_reg_commit_value, 64'h9);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_in();
      in_rg_done = 1; in_rg_dst = 5'(i + 1);
      cyc();
    end
    idle_in();
    #2;
    in_rst = 1;
    #1;
    chk("arst_next", out_reg_next_rob_index, 0);
    chk("arst_rsd", out_rs_done, 0);
    chk("arst_rsi", out_rs_rob_index, 0);
    chk("arst_cm", out_reg_should_commit, 0);
    @(posedge in_clk);
    #1;
    in_rst = 0;
    model_clear();
    in_fu_done = 1; in_fu_rob_index = 3; in_fu_value = 64'h99;
    cyc();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("arst_nocm", out_reg_should_commit, 0);
    end

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle_in();
      in_rg_done = ($urandom_range(0, 99) < 55);
      in_rg_dst = 5'($urandom);
      in_rg_set_nzcv = 1'($urandom);
      in_rg_src1_valid = 1'($urandom);
      in_rg_src2_valid = 1'($urandom);
      in_rg_src1_value = {$urandom, $urandom};
      in_rg_src2_value = {$urandom, $urandom};
      in_rg_src1_rob_index = 3'($urandom);
      in_rg_src2_rob_index = 3'($urandom);
      in_fu_done = ($urandom_range(0, 99) < 50);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        in_fu_rob_index = q[$urandom_range(0, q.size() - 1)].idx;
      else
        in_fu_rob_index = 3'($urandom);
      in_fu_value = {$urandom, $urandom};
      in_fu_nzcv = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer on the far side of the rename/regfile dispatch interface. It allocates one entry per instruction dispatched by the regfile and returns the next free ROB index to it. It captures functional-unit results, resolves pending source operands for the reservation stations, and retires entries in program order by driving the regfile commit port.

Parameters:
ROB_ENTRIES, 8, number of entries; power of two
ROB_IDX_SIZE, 3, log2(ROB_ENTRIES)
GPR_SIZE, 64, register value width
GPR_IDX_SIZE, 5, architectural register index width

Ports:
in_clk  input  1  clock
in_rst  input  1  asynchronous active-high reset
in_rg_done  input  1  regfile dispatch valid
in_rg_dst  input  GPR_IDX_SIZE  destination GPR
in_rg_set_nzcv  input  1  instruction writes NZCV
in_rg_src1_valid / in_rg_src2_valid  input  1  operand already architectural
in_rg_src1_value / in_rg_src2_value  input  GPR_SIZE  operand value when valid
in_rg_src1_rob_index / in_rg_src2_rob_index  input  ROB_IDX_SIZE  producer tag when invalid
in_fu_done  input  1  FU result broadcast valid
in_fu_rob_index  input  ROB_IDX_SIZE  completing entry
in_fu_value  input  GPR_SIZE  result
in_fu_nzcv  input  4  result flags
out_reg_next_rob_index  output  ROB_IDX_SIZE  tail index the next dispatch will receive
out_full  output  1  count == ROB_ENTRIES
out_rs_done  output  1  resolved dispatch valid to reservation stations
out_rs_rob_index  output  ROB_IDX_SIZE  entry allocated to that dispatch
out_rs_src1_valid / out_rs_src2_valid  output  1  resolved operand valid
out_rs_src1_value / out_rs_src2_value  output  GPR_SIZE  resolved value
out_rs_src1_rob_index / out_rs_src2_rob_index  output  ROB_IDX_SIZE  tag to wait on
out_reg_should_commit  output  1  commit pulse
out_reg_commit_rob_index  output  ROB_IDX_SIZE  retiring entry
out_reg_reg_index  output  GPR_IDX_SIZE  destination GPR
out_reg_commit_value  output  GPR_SIZE  committed value
out_reg_set_nzcv  output  1  commit also writes NZCV
out_reg_nzcv  output  4  committed flags
out_overflow  output  1  sticky: dispatch arrived while full

Behaviour:
- Reset (async, in_rst=1): head = tail = count = 0; every entry valid = 0, done = 0; every registered output = 0. out_reg_next_rob_index = 0. Reset mid-operation discards all entries.
- Entry state: valid, done, dst, set_nzcv, value, nzcv.
- out_reg_next_rob_index = tail, combinational from a register. out_full = (count == ROB_ENTRIES), combinational.
- Allocate: on in_rg_done with !out_full, entry[tail] takes valid=1, done=0, dst and set_nzcv. Tail advances by 1, wrapping at ROB_ENTRIES-1 to 0.
- Dispatch while full: the dispatch is dropped, tail is unchanged, and out_overflow sets and stays set until reset.
- Operand resolution, latency 1: the cycle after an accepted dispatch, out_rs_done=1 and out_rs_rob_index = the allocated index. For each src:
  - valid input passes through unchanged.
  - Otherwise, if entry[tag].done, or in_fu_done with in_fu_rob_index==tag in the same cycle, output valid=1 with that value. The FU bypass has priority.
  - Otherwise valid=0 with the tag.
- out_rs_done is 0 on cycles without an accepted dispatch.
- Completion: in_fu_done writes value and nzcv and sets done=1 at in_fu_rob_index only if that entry is valid; otherwise the broadcast is ignored.
- Commit, at most one per cycle: if count>0 and entry[head].done at a clock edge, the following outputs register from entry[head] for exactly one cycle:
  - out_reg_should_commit = 1
  - out_reg_commit_rob_index = head
  - out_reg_reg_index, out_reg_commit_value, out_reg_set_nzcv, out_reg_nzcv
  - In the same edge, entry[head].valid clears and head advances with wrap.
- Commit outputs are otherwise 0 / hold last value; only should_commit is meaningful.
- A result completing the head entry in cycle N commits at the edge ending cycle N+1, so there is no same-cycle completion-to-commit path.
- Simultaneous allocate and commit: count unchanged; allocation into the slot freed this edge is legal only if count was not full before the edge.
- Count width: ROB_IDX_SIZE+1 bits; it never exceeds ROB_ENTRIES and never underflows.

Test Plan:
- Reset, 3 dispatches (dst 1,2,3) -> out_reg_next_rob_index 0,1,2,3; out_rs_rob_index 0,1,2 one cycle after each; count 3.
- Complete entries 2, then 0, then 1 (values 30,10,20) -> commits in order idx0/GPR1=10, idx1/GPR2=20, idx2/GPR3=30, one per cycle.
- Dispatch with src1 invalid tag 0 while in_fu_done idx0 value 0x55 same cycle -> out_rs_src1_valid=1, value 0x55.
- Fill 8 entries -> out_full=1; 9th dispatch -> out_overflow=1, tail stays 0. Commit one -> out_full=0; next dispatch gets index 0 (wrap).
- Head completes with set_nzcv=1, nzcv=4'b0100 -> out_reg_set_nzcv=1, out_reg_nzcv=0100 in the commit cycle.
- Assert in_rst mid-stream with 5 entries pending -> all outputs 0 immediately; a later FU broadcast to idx 3 produces no commit.
